// File: rtl/spi_rom_quad_reader_pkg.sv
// Shared types and constants for the quad-output SPI ROM reader.
package spi_rom_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_STREAM
    } state_t;

    // Quad Output Fast Read opcode and its serial length on io0.
    localparam logic [7:0] CMD_QUAD_READ = 8'h6B;
    localparam int         CMD_BITS      = 8;
    localparam int         CMD_CLKS      = 2 * CMD_BITS;

endpackage

// File: rtl/spi_rom_quad_reader_if.sv
// Control, ROM pad and byte-stream signals of the quad SPI ROM reader.
interface spi_rom_quad_reader_if #(
    parameter int ADDR_W = 24
);
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        spi_in;
    logic              spi_cs_n;
    logic              spi_sclk;
    logic              spi_out0;
    logic              spi_dir0;
    logic [7:0]        data;
    logic              data_valid;
    logic              data_ready;
    logic              busy;

    // Reader side.
    modport slave (
        input  start, stop, addr, spi_in, data_ready,
        output spi_cs_n, spi_sclk, spi_out0, spi_dir0, data, data_valid, busy
    );

    // Controller / ROM / consumer side.
    modport master (
        output start, stop, addr, spi_in, data_ready,
        input  spi_cs_n, spi_sclk, spi_out0, spi_dir0, data, data_valid, busy
    );
endinterface

// File: rtl/spi_rom_quad_reader_byte_fifo.sv
// Small synchronous byte FIFO; head is visible combinationally from storage.
module byte_fifo #(
    parameter int  DEPTH = 4,
    parameter int  W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [AW-1:0]           wr_q, rd_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Storage, pointers and count; flush empties without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/spi_rom_quad_reader.sv
// Quad Output Fast Read streamer: sends 0x6B + address on io0, waits the
// dummy clocks, then reads nibbles on io[3:0] into a byte FIFO with
// SCLK stretching when the FIFO has no room for another byte.
module spi_rom_quad_reader
    import spi_rom_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DUMMY_CLKS = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_rom_quad_reader_if.slave  bus
);
    localparam int SR_W  = CMD_BITS + ADDR_W;
    localparam int CNT_W = $clog2(SR_W + DUMMY_CLKS + 1);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    state_t           state_q;
    logic             phase_q;     // SCLK level: 0 = low half, 1 = high half
    logic             cs_n_q;
    logic             out0_q;
    logic             dir0_q;
    logic             nib_q;       // 0 = high nibble pending, 1 = low nibble pending
    logic [3:0]       hi_q;
    logic [SR_W-2:0]  sr_q;        // remaining MOSI bits; opcode MSB goes out at start
    logic [CNT_W-1:0] bit_q;       // SCLK periods completed in the current phase
    logic             bit_last;

    logic [CW-1:0]    fifo_cnt;
    logic             fifo_full, fifo_empty;
    logic             pop, push, room;
    logic [7:0]       fifo_dout;

    assign pop  = !fifo_empty && bus.data_ready;
    // Count is taken after this cycle's pop, so a pop immediately unblocks a byte.
    assign room = (fifo_cnt < CW'(FIFO_DEPTH)) || pop;
    // Byte completes at the edge ending its second high phase.
    assign push = (state_q == ST_STREAM) && phase_q && nib_q && !bus.stop && (!fifo_full || pop);

    // Last SCLK period of the fixed-length phases.
    always_comb begin
        bit_last = 1'b0;
        case (state_q)
            ST_CMD:   bit_last = (bit_q == CNT_W'(CMD_BITS - 1));
            ST_ADDR:  bit_last = (bit_q == CNT_W'(ADDR_W - 1));
            ST_DUMMY: bit_last = (bit_q == CNT_W'(DUMMY_CLKS - 1));
            default:  bit_last = 1'b0;
        endcase
    end

    // Sequencer: state, SCLK phase, MOSI shifter, nibble capture and pad controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            cs_n_q  <= 1'b1;
            out0_q  <= 1'b0;
            dir0_q  <= 1'b0;
            nib_q   <= 1'b0;
            hi_q    <= '0;
            sr_q    <= '0;
            bit_q   <= '0;
        end else if (bus.stop) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            cs_n_q  <= 1'b1;
            out0_q  <= 1'b0;
            dir0_q  <= 1'b0;
            nib_q   <= 1'b0;
            bit_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_CMD;
                        cs_n_q  <= 1'b0;
                        phase_q <= 1'b0;
                        out0_q  <= CMD_QUAD_READ[7];
                        sr_q    <= {CMD_QUAD_READ[6:0], bus.addr};
                        bit_q   <= '0;
                    end
                end
                ST_CMD, ST_ADDR: begin
                    phase_q <= !phase_q;
                    if (phase_q) begin
                        if (bit_last) begin
                            bit_q   <= '0;
                            state_q <= (state_q == ST_CMD) ? ST_ADDR : ST_DUMMY;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                        // io0 turns around as soon as the address is done.
                        if (state_q == ST_ADDR && bit_last) begin
                            out0_q <= 1'b0;
                            dir0_q <= 1'b1;
                        end else begin
                            out0_q <= sr_q[SR_W-2];
                            sr_q   <= sr_q << 1;
                        end
                    end
                end
                ST_DUMMY: begin
                    phase_q <= !phase_q;
                    if (phase_q) begin
                        if (bit_last) begin
                            bit_q   <= '0;
                            nib_q   <= 1'b0;
                            state_q <= ST_STREAM;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (phase_q) begin
                        phase_q <= 1'b0;
                        nib_q   <= !nib_q;
                        if (!nib_q) hi_q <= bus.spi_in;
                    end else if (nib_q || room) begin
                        // A new byte only rises SCLK when it has a FIFO slot.
                        phase_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   ({hi_q, bus.spi_in}),
        .pop_i   (pop),
        .flush_i (bus.stop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign bus.spi_cs_n   = cs_n_q;
    assign bus.spi_sclk   = phase_q;
    assign bus.spi_out0   = out0_q;
    assign bus.spi_dir0   = dir0_q;
    assign bus.data       = fifo_dout;
    assign bus.data_valid = !fifo_empty;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: doc/spi_rom_quad_reader.md
# spi_rom_quad_reader

Streams bytes from an external SPI flash ROM using the Quad Output Fast Read command (0x6B) and buffers them in a small FIFO for the pixel/render logic. It drives the ROM chip-select, SCLK and the bidirectional io0 line, including its direction, and samples all four io lines in quad phase. It sits between the ROM pads (`spi_cs_n`, `spi_sclk`, `spi_out0`, `spi_dir0`, `spi_in[3:0]`) and the VGA render stage, which pops bytes via a valid/ready handshake.

## Interface
- `ADDR_W`, 24: ROM address width; sent MSB first.
- `DUMMY_CLKS`, 8: SCLK cycles between address and first data nibble.
- `FIFO_DEPTH`, 4: byte FIFO depth; power of 2, ≥2.
- `clk` in 1: pixel clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a read at `addr`; honoured only in IDLE.
- `stop` in 1: abort the stream, deassert CS and flush the FIFO.
- `addr` in ADDR_W: start address, captured on an accepted `start`.
- `spi_in` in 4: ROM io[3:0]; io[0] is meaningful only while `spi_dir0`=1.
- `spi_cs_n` out 1: ROM chip select, active low.
- `spi_sclk` out 1: ROM clock, clk/2 while active.
- `spi_out0` out 1: MOSI data on io0 during CMD/ADDR.
- `spi_dir0` out 1: 0 = io0 driven by us, 1 = io0 is input.
- `data` out 8: FIFO head byte.
- `data_valid` out 1: FIFO non-empty.
- `data_ready` in 1: consumer pops when `data_valid && data_ready`.
- `busy` out 1: state ≠ IDLE.

## Operation
- Reset values: `spi_cs_n`=1, `spi_sclk`=0, `spi_out0`=0, `spi_dir0`=0, `data_valid`=0, `busy`=0, `data`=0, FIFO empty, state IDLE.
- States: IDLE → CMD (8 bits, 0x6B) → ADDR (ADDR_W bits) → DUMMY (DUMMY_CLKS) → STREAM (unbounded) → IDLE on `stop`.
- A `phase` register toggles every clk while active; `spi_sclk` = `phase`. Each SCLK period is 2 clk: low, then high.
- CMD/ADDR: `spi_out0` updates on entry to the low phase, MSB first. The ROM samples it on SCLK rise. `spi_dir0`=0.
- `spi_dir0` goes 1 on the first DUMMY cycle and stays 1 until IDLE.
- STREAM: `spi_in` is sampled at the clk edge ending each high phase. The high nibble comes first, the low nibble second. The byte is pushed into the FIFO at the edge that samples its low nibble.
- Backpressure: a new byte's first low phase starts only if the FIFO count < FIFO_DEPTH. Otherwise `spi_sclk` is held 0 and `spi_cs_n` stays 0 (clock stretch). Only one byte is in flight, so overflow cannot occur.
- Simultaneous push and pop leave the count unchanged.
- `stop`, in any non-IDLE state, gives this on the next clk: `spi_cs_n`=1, `spi_sclk`=0, `spi_dir0`=0, FIFO flushed, IDLE. A partial byte is discarded.
- `start` and `stop` in the same IDLE cycle: `stop` wins, nothing starts.
- `start` while busy is ignored.
- Address wrap is handled by the ROM; the block keeps no address counter.
- Asynchronous reset mid-transfer returns all outputs to their reset values immediately.

## Timing
- `start` is accepted at edge E0. `spi_cs_n` falls and CMD begins in the cycle after E0.
- CMD takes 16 clk, ADDR 2·ADDR_W clk, DUMMY 2·DUMMY_CLKS clk.
- The first byte is pushed at edge E0 + 16 + 2·ADDR_W + 2·DUMMY_CLKS + 4. With defaults that is E0+84, so `data_valid` rises in cycle 85.
- Steady-state throughput: 1 byte per 4 clk when the consumer is always ready.
- FIFO read is zero-latency: `data` shows the head combinationally from registered storage.
- A pop frees space in the same cycle as far as the next byte-start decision is concerned (count evaluated after pop).

## Structure
- Package `spi_rom_pkg` holds:
  - the state enum;
  - `CMD_QUAD_READ`=8'h6B;
  - the bit-count constants for CMD.
- Sub-module `byte_fifo` is a synchronous FIFO with async active-low reset and ports push/pop/flush/full/empty/count.
- The FSM, phase toggle and shift registers live in the top module.

## Test plan
- Reset, then `start` with addr=24'h123456: MOSI carries 0x6B then 0x123456 MSB-first over 16+48 clk; `spi_dir0` rises at cycle 65; the first byte appears in cycle 85.
- ROM model returns 0xA5, 0x3C, … with `data_ready` held 1: bytes arrive every 4 clk, in order, with no gaps.
- `data_ready`=0 for 30 clk during STREAM: the FIFO fills to 4 and `spi_sclk` stays 0 with `spi_cs_n`=0; after release the stream resumes with no lost or duplicated bytes.
- `stop` two clk into a byte: `spi_cs_n`=1 next cycle, `data_valid`=0, the partial byte is never output, and `busy`=0.
- `start` and `stop` asserted together in IDLE: `spi_cs_n` stays 1. A `start` during STREAM is ignored, and the address is not re-sent.
- `rst_n` pulled low mid-ADDR: all outputs return to reset values asynchronously; a subsequent `start` performs a clean, full transaction.
